// File: rtl/mult32x32_arith_if.sv
// Control/data bundle between the multiplier FSM (master) and the arithmetic stage (slave).
interface mult32x32_arith_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [2:0]  shift_sel;
  logic        upd_prod;
  logic        clr_prod;
  logic [63:0] product;
  logic        prod_valid;
  logic        proto_err;

  modport master (
    output a, b, busy, a_sel, b_sel, shift_sel, upd_prod, clr_prod,
    input  product, prod_valid, proto_err
  );

  modport slave (
    input  a, b, busy, a_sel, b_sel, shift_sel, upd_prod, clr_prod,
    output product, prod_valid, proto_err
  );
endinterface

// File: rtl/mult32x32_arith.sv
// 32x32 multiplier datapath: captures operands, accumulates one shifted 8x16 partial
// product per update cycle into a 64-bit product register.
module mult32x32_arith (
  input  logic                    clk,
  input  logic                    reset,
  mult32x32_arith_if.slave        bus
);

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] product_q, product_d;
  logic        valid_q, valid_d;
  logic        open_q, open_d;
  logic        proto_err_q, proto_err_d;

  logic [7:0]  a_byte;
  logic [15:0] b_word;
  logic [23:0] pp;
  logic [63:0] pp_ext;
  logic [63:0] pp_shifted;

  always_comb begin
    a_byte = 8'd0;
    unique case (bus.a_sel)
      2'd0: a_byte = a_q[7:0];
      2'd1: a_byte = a_q[15:8];
      2'd2: a_byte = a_q[23:16];
      2'd3: a_byte = a_q[31:24];
      default: a_byte = 8'd0;
    endcase
  end

  assign b_word = bus.b_sel ? b_q[31:16] : b_q[15:0];
  assign pp     = {16'd0, a_byte} * {8'd0, b_word};
  assign pp_ext = {40'd0, pp};

  // Shift selects 6 and 7 are out of range and contribute nothing.
  assign pp_shifted = (bus.shift_sel > 3'd5) ? 64'd0 : (pp_ext << {bus.shift_sel, 3'b000});

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    product_d   = product_q;
    valid_d     = valid_q;
    open_d      = open_q;
    proto_err_d = proto_err_q;
    if (bus.clr_prod) begin
      product_d = 64'd0;
      a_d       = bus.a;
      b_d       = bus.b;
      valid_d   = 1'b0;
      open_d    = 1'b1;
    end else if (bus.upd_prod) begin
      product_d = product_q + pp_shifted;
      if (!bus.busy) begin
        valid_d = 1'b1;
        open_d  = 1'b0;
      end
      // Accumulation still happens on a stray update; it is only flagged.
      if (!open_q) begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      product_q   <= 64'd0;
      valid_q     <= 1'b0;
      open_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      product_q   <= product_d;
      valid_q     <= valid_d;
      open_q      <= open_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.product    = product_q;
  assign bus.prod_valid = valid_q;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: doc/mult32x32_arith.md
Name: mult32x32_arith

Overview:
- Datapath stage directly downstream of the 32x32 multiplier control FSM; consumes its a_sel/b_sel/shift_sel/upd_prod/clr_prod/busy outputs.
- Captures the operands, forms one 8x16 partial product per cycle, shifts it into position and accumulates it into a 64-bit product register.
- Flags when the product is final.
- Sequential content: operand registers, accumulator, completion flag, protocol-error flag.

Parameters:
- None. Widths are fixed: 32-bit operands, 64-bit product.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- a  in  32  multiplicand; sampled only on a clear cycle
- b  in  32  multiplier; sampled only on a clear cycle
- busy  in  1  FSM busy indication
- a_sel  in  2  byte select of captured A: 0=[7:0], 1=[15:8], 2=[23:16], 3=[31:24]
- b_sel  in  1  word select of captured B: 0=[15:0], 1=[31:16]
- shift_sel  in  3  left shift of partial product = 8*shift_sel bits, for values 0..5; 6 and 7 give a zero partial product
- upd_prod  in  1  accumulate the shifted partial product into the product register
- clr_prod  in  1  clear the product register and capture a/b
- product  out  64  product register, direct register output
- prod_valid  out  1  product is final and held
- proto_err  out  1  sticky: upd_prod seen while no operation is open

Behaviour:
- Reset (reset=0, async):
  - a_reg=0, b_reg=0, product=0.
  - prod_valid=0, proto_err=0, open flag=0.
  - Applying reset mid-operation aborts it; no partial state survives.
- Partial product (combinational, internal):
  - pp = a_reg byte[a_sel] (8b unsigned) x b_reg word[b_sel] (16b unsigned), giving 24 bits.
  - pp is zero-extended to 64 bits, then shifted left by 8*shift_sel.
  - Bits shifted beyond bit 63 are discarded; at shift 40 the max term reaches bit 63 exactly, so nothing is lost in legal use.
- Register update at each rising clk, in priority order:
  1. clr_prod=1:
     - product <= 0; a_reg <= a; b_reg <= b.
     - prod_valid <= 0; open <= 1.
     - upd_prod in the same cycle is ignored: clear wins and no pp is added.
  2. else upd_prod=1:
     - product <= product + shifted pp, modulo 2^64.
     - If busy=0, this is the final accumulation: prod_valid <= 1 and open <= 0.
     - If open=0 at that edge: proto_err <= 1. The addition is still performed.
  3. else: all registers hold.
- Operands:
  - a/b are ignored outside clear cycles; changing them mid-operation must not affect the result.
- prod_valid:
  - Rises the cycle after the final accumulation edge and stays high until the next clr_prod or reset.
  - While prod_valid=1, product is stable.
- Accumulation sequence:
  - A standard 8-step sequence runs a_sel/b_sel/shift_sel over (1,0,1),(2,0,2),(3,0,3),(0,1,2),(1,1,3),(2,1,4),(3,1,5), then the final step (0,0,0) with busy=0.
  - It yields the exact unsigned a*b.
  - The block does not enforce step order; it accumulates whatever it is given.
- Latency:
  - Clear cycle plus 8 update cycles.
  - product final and prod_valid=1 one edge after the last update, i.e. 9 edges after the clr edge.
- Back-to-back:
  - clr_prod in the cycle immediately after the final update is legal.
  - prod_valid drops at that edge.
- proto_err is cleared only by reset.

Test Plan:
- Reset, then run the standard sequence with a=5, b=7 -> product=64'd35; prod_valid=1 exactly 9 edges after the clr edge; proto_err=0.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF, standard sequence -> product=64'hFFFFFFFE00000001 with no wrap error; then a=32'h12345678, b=32'h9ABCDEF0 back-to-back -> prod_valid low for 9 edges, then product=64'h0B00EA4E242D2080.
- clr_prod=1 and upd_prod=1 together with a=b=32'hFF -> product=0 after the edge; a/b captured, no pp added.
- Change a/b every cycle after the clear cycle (a=3, b=4 captured) -> product=12; product then holds while a/b keep toggling and no clr_prod is given.
- Single update with shift_sel=6 or 7 -> product unchanged; upd_prod after completion without clr_prod -> proto_err=1 and stays 1 until reset.
- Assert reset=0 mid-sequence (after 4 updates) -> product=0, prod_valid=0 immediately, without waiting for a clock edge; release reset and rerun 5x7 -> 35.
